// File: rtl/sub_bytes_iter_if.sv
// Handshake bundle for sub_bytes_iter: input state transfer, output state transfer and busy flag.
// slave is the block's view; master is the view of the upstream/downstream logic driving it.
interface sub_bytes_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_i;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_o;
    logic         busy;

    modport slave (
        input  in_valid,
        input  state_i,
        input  out_ready,
        output in_ready,
        output out_valid,
        output state_o,
        output busy
    );

    modport master (
        output in_valid,
        output state_i,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  state_o,
        input  busy
    );
endinterface

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: one 32-bit word per cycle through four shared forward S-box lanes.
// Define SUBBYTES_SBOX_REG_EN to register the S-box output before write-back (5-cycle latency).
module sub_bytes_iter (
    input  logic              clk,
    input  logic              rst,
    sub_bytes_iter_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t       r_state;
    logic [1:0]   r_cnt;
    logic [127:0] r_work;
    logic [127:0] r_out;

    logic [31:0]  w_rd_word;
    logic [31:0]  w_sbox_word;
    logic [1:0]   w_wb_idx;
    logic [31:0]  w_wb_word;
    logic         w_wb_en;
    logic         w_last;
    logic [127:0] w_work_nxt;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = prod x^(2^i), i=1..7; yields 0 for x=0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]}
               ^ 8'h63;
    endfunction

    always_comb begin
        w_sbox_word = '0;
        w_rd_word   = r_work[{r_cnt, 5'd0} +: 32];
        for (int l = 0; l < 4; l++) begin
            w_sbox_word[8*l +: 8] = sbox(w_rd_word[8*l +: 8]);
        end
    end

`ifdef SUBBYTES_SBOX_REG_EN
    logic [31:0] r_pipe;
    logic        r_drain;

    // Write-back trails issue by one cycle; the drain cycle retires word 3.
    assign w_wb_idx  = r_cnt - 2'd1;
    assign w_wb_word = r_pipe;
    assign w_wb_en   = (r_cnt != 2'd0) || r_drain;
    assign w_last    = r_drain;
`else
    assign w_wb_idx  = r_cnt;
    assign w_wb_word = w_sbox_word;
    assign w_wb_en   = 1'b1;
    assign w_last    = (r_cnt == 2'd3);
`endif

    always_comb begin
        w_work_nxt = r_work;
        if (w_wb_en) w_work_nxt[{w_wb_idx, 5'd0} +: 32] = w_wb_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= 2'd0;
            r_work  <= '0;
            r_out   <= '0;
`ifdef SUBBYTES_SBOX_REG_EN
            r_pipe  <= '0;
            r_drain <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        r_work  <= bus.state_i;
                        r_cnt   <= 2'd0;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_work <= w_work_nxt;
`ifdef SUBBYTES_SBOX_REG_EN
                    r_pipe <= w_sbox_word;
                    if (!r_drain) r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) r_drain <= 1'b1;
                    if (w_last) r_drain <= 1'b0;
`else
                    r_cnt  <= r_cnt + 2'd1;
`endif
                    if (w_last) begin
                        r_out   <= w_work_nxt;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    // Output handshake; a simultaneous accept restarts without a bubble.
                    if (bus.out_ready) begin
                        if (bus.in_valid) begin
                            r_work  <= bus.state_i;
                            r_cnt   <= 2'd0;
                            r_state <= StRun;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == StIdle) || ((r_state == StDone) && bus.out_ready);
    assign bus.out_valid = (r_state == StDone);
    assign bus.busy      = (r_state == StRun);
    assign bus.state_o   = r_out;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter: FIPS-197 vector, S-box corners, backpressure,
// back-to-back transfers, ignored input while busy and reset mid-run.
module tb_sub_bytes_iter;

`ifdef SUBBYTES_SBOX_REG_EN
    localparam int Lat = 5;
`else
    localparam int Lat = 4;
`endif

    localparam logic [127:0] VFips = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] EFips = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    sub_bytes_iter_if bus ();

    sub_bytes_iter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one vector, garble state_i (with in_valid high) while busy, wait, check, drain.
    task automatic run_one(input logic [127:0] v, input logic [127:0] e, input string tag,
                           input bit hold);
        int n;
        bus.state_i  = v;
        bus.in_valid = 1'b1;
        check_eq({tag, "_in_ready"}, bus.in_ready, 1);
        step();
        check_eq({tag, "_busy"}, {bus.busy, bus.in_ready}, 2'b10);
        bus.state_i = ~v;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
            if (n == 2) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        check_eq({tag, "_latency"}, n, Lat);
        check_eq({tag, "_state_o"}, bus.state_o, e);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                step();
                check_eq({tag, "_hold_data"}, bus.state_o, e);
                check_eq({tag, "_hold_vld_rdy"}, {bus.out_valid, bus.in_ready}, 2'b10);
            end
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_eq({tag, "_post_vld"}, bus.out_valid, 0);
        check_eq({tag, "_post_rdy"}, bus.in_ready, 1);
        step();
        check_eq({tag, "_once"}, bus.out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.state_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_state_o", bus.state_o, 0);
        check_eq("rst_vld_rdy_busy", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
        rst = 1'b0;
        step();

        run_one(VFips, EFips, "fips", 1'b1);
        run_one({16{8'h00}}, {16{8'h63}}, "all00", 1'b0);
        run_one({16{8'hff}}, {16{8'h16}}, "allff", 1'b0);

        // Back-to-back: second accept coincides with the first output handshake.
        bus.out_ready = 1'b1;
        bus.state_i   = {16{8'h01}};
        bus.in_valid  = 1'b1;
        step();
        bus.state_i = {16{8'h53}};
        repeat (Lat - 1) step();
        check_eq("b2b_a_early", bus.out_valid, 0);
        step();
        check_eq("b2b_a_vld_rdy", {bus.out_valid, bus.in_ready}, 2'b11);
        check_eq("b2b_a_data", bus.state_o, {16{8'h7c}});
        step();
        bus.in_valid = 1'b0;
        check_eq("b2b_no_bubble", {bus.out_valid, bus.busy}, 2'b01);
        repeat (Lat - 1) step();
        check_eq("b2b_b_early", bus.out_valid, 0);
        step();
        check_eq("b2b_b_vld", bus.out_valid, 1);
        check_eq("b2b_b_data", bus.state_o, {16{8'hed}});
        step();
        bus.out_ready = 1'b0;
        check_eq("b2b_b_done", bus.out_valid, 0);

        // Reset at cnt==2 aborts the run; state_o was nonzero before.
        bus.state_i  = VFips;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check_eq("midrst_state_o", bus.state_o, 0);
        check_eq("midrst_vld_rdy_busy", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
        rst = 1'b0;
        step();
        run_one(VFips, EFips, "after_rst", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
